// File: rtl/in_packet.sv
// in_packet: ingress stage ahead of the packet FIFO. Accepts large packets on InBus and
// writes them word-aligned into the FIFO. A packet is admitted at Sop only if the FIFO can
// hold all of it. Framing and header length are checked as the packet is written.
// Optional statistics counters (stat_pkts/stat_drops/stat_errs) are built when the
// PKT_STATS_EN macro is defined.

module in_packet #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 512,
  localparam int unsigned BYTES = DATA_WIDTH / 8,
  localparam int unsigned MW    = $clog2(BYTES) + 1,
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  InBus_Val,
  input  logic                  InBus_Sop,
  input  logic                  InBus_Eop,
  input  logic [MW-1:0]         InBus_Mod,
  input  logic [DATA_WIDTH-1:0] InBus_Dat,
  input  logic [CW-1:0]         fifo_count,
  output logic                  fifo_wr,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  pkt_drop,
  output logic                  InBus_Error
`ifdef PKT_STATS_EN
  ,
  output logic [31:0]           stat_pkts,
  output logic [15:0]           stat_drops,
  output logic [15:0]           stat_errs
`endif
);

  localparam int unsigned LogB = $clog2(BYTES);
  // Wide enough to add need + fifo_count + in-flight write without wrapping.
  localparam int unsigned SW   = 18;

  typedef enum logic [1:0] {StIdle, StStore, StDiscard} state_e;

  state_e                  state_q, state_d;
  logic [16:0]             byte_cnt_q, byte_cnt_d;
  logic [15:0]             hdr_len_q, hdr_len_d;
  logic [16:0]             need_q, need_d;
  logic [16:0]             wcnt_q, wcnt_d;
  logic                    wr_d, drop_d, err_d;
  logic [DATA_WIDTH-1:0]   data_d;
`ifdef PKT_STATS_EN
  logic                    pkt_done_d, pkt_done_q;
`endif

  logic [15:0]             sop_len;
  logic [SW-1:0]           sop_need;
  logic                    sop_fits;
  logic [31:0]             mask_shift;
  logic [DATA_WIDTH-1:0]   byte_mask;
  logic [DATA_WIDTH-1:0]   masked_dat;
  logic [16:0]             add_sum;

  // Admission arithmetic for a packet header on the bus; the write already in flight
  // is not yet reflected in fifo_count, so it is charged here.
  always_comb begin
    sop_len  = InBus_Dat[DATA_WIDTH-1 -: 16];
    sop_need = SW'((17'(sop_len) + 17'(BYTES - 1)) >> LogB);
    sop_fits = (sop_need + SW'(fifo_count) + SW'(fifo_wr)) <= SW'(FIFO_DEPTH);
  end

  // Zero the invalid trailing bytes of the word (valid bytes are MSB-first).
  always_comb begin
    mask_shift = (BYTES - 32'(InBus_Mod)) * 8;
    if (32'(InBus_Mod) >= BYTES) begin
      byte_mask = '1;
    end else begin
      byte_mask = {DATA_WIDTH{1'b1}} << mask_shift;
    end
    masked_dat = InBus_Dat & byte_mask;
  end

  // Next-state and next-output decode for the packet state machine.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hdr_len_d  = hdr_len_q;
    need_d     = need_q;
    wcnt_d     = wcnt_q;
    wr_d       = 1'b0;
    data_d     = fifo_data_in;
    drop_d     = 1'b0;
    err_d      = 1'b0;
    add_sum    = '0;
`ifdef PKT_STATS_EN
    pkt_done_d = 1'b0;
`endif
    if (InBus_Val) begin
      if (InBus_Sop) begin
        // A new header while a packet is open closes it without its Eop.
        if (state_q == StStore) err_d = 1'b1;
        if (sop_len < 16'd2) begin
          err_d   = 1'b1;
          state_d = InBus_Eop ? StIdle : StDiscard;
        end else if (!sop_fits) begin
          drop_d  = 1'b1;
          state_d = InBus_Eop ? StIdle : StDiscard;
        end else begin
          wr_d       = 1'b1;
          data_d     = masked_dat;
          byte_cnt_d = 17'(InBus_Mod);
          hdr_len_d  = sop_len;
          need_d     = 17'(sop_need);
          wcnt_d     = 17'd1;
          if (InBus_Eop) begin
            state_d = StIdle;
`ifdef PKT_STATS_EN
            pkt_done_d = 1'b1;
`endif
            if (17'(InBus_Mod) != {1'b0, sop_len}) err_d = 1'b1;
          end else begin
            state_d = StStore;
          end
        end
      end else begin
        unique case (state_q)
          StIdle: err_d = 1'b1;
          StStore: begin
            add_sum    = InBus_Eop ? (byte_cnt_q + 17'(InBus_Mod)) : (byte_cnt_q + 17'(BYTES));
            byte_cnt_d = add_sum;
            if (add_sum[16]) begin
              // Byte count overflow: drop the rest of this packet.
              err_d   = 1'b1;
              state_d = InBus_Eop ? StIdle : StDiscard;
            end else begin
              // Words beyond the admitted size would overrun the reserved space.
              if (wcnt_q < need_q) begin
                wr_d   = 1'b1;
                data_d = masked_dat;
                wcnt_d = wcnt_q + 17'd1;
              end else begin
                err_d = 1'b1;
              end
              if (InBus_Eop) begin
                state_d = StIdle;
`ifdef PKT_STATS_EN
                pkt_done_d = 1'b1;
`endif
                if (add_sum != {1'b0, hdr_len_q}) err_d = 1'b1;
              end else if (InBus_Mod != MW'(BYTES)) begin
                err_d = 1'b1;
              end
            end
          end
          StDiscard: if (InBus_Eop) state_d = StIdle;
          default:   state_d = StIdle;
        endcase
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      hdr_len_q    <= '0;
      need_q       <= '0;
      wcnt_q       <= '0;
      fifo_wr      <= 1'b0;
      fifo_data_in <= '0;
      pkt_drop     <= 1'b0;
      InBus_Error  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      hdr_len_q    <= hdr_len_d;
      need_q       <= need_d;
      wcnt_q       <= wcnt_d;
      fifo_wr      <= wr_d;
      fifo_data_in <= data_d;
      pkt_drop     <= drop_d;
      InBus_Error  <= err_d;
    end
  end

`ifdef PKT_STATS_EN
  // Saturating event counters, counting the registered pulses one cycle later.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pkt_done_q <= 1'b0;
      stat_pkts  <= '0;
      stat_drops <= '0;
      stat_errs  <= '0;
    end else begin
      pkt_done_q <= pkt_done_d;
      if (pkt_done_q && (stat_pkts != '1)) stat_pkts <= stat_pkts + 32'd1;
      if (pkt_drop && (stat_drops != '1)) stat_drops <= stat_drops + 16'd1;
      if (InBus_Error && (stat_errs != '1)) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_in_packet.sv
// Testbench for in_packet: packet-level reference model feeding a scoreboard of expected
// output events, checked by an independent monitor.

module tb_in_packet;

  localparam int DW    = 64;
  localparam int DEPTH = 512;
  localparam int B     = DW / 8;
  localparam int MW    = $clog2(B) + 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          InBus_Val = 1'b0;
  logic          InBus_Sop = 1'b0;
  logic          InBus_Eop = 1'b0;
  logic [MW-1:0] InBus_Mod = '0;
  logic [DW-1:0] InBus_Dat = '0;
  logic [CW-1:0] fifo_count = '0;
  logic          fifo_wr;
  logic [DW-1:0] fifo_data_in;
  logic          pkt_drop;
  logic          InBus_Error;
`ifdef PKT_STATS_EN
  logic [31:0]   stat_pkts;
  logic [15:0]   stat_drops;
  logic [15:0]   stat_errs;
`endif

  in_packet #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .InBus_Val(InBus_Val), .InBus_Sop(InBus_Sop),
    .InBus_Eop(InBus_Eop), .InBus_Mod(InBus_Mod), .InBus_Dat(InBus_Dat),
    .fifo_count(fifo_count), .fifo_wr(fifo_wr), .fifo_data_in(fifo_data_in),
    .pkt_drop(pkt_drop), .InBus_Error(InBus_Error)
`ifdef PKT_STATS_EN
    , .stat_pkts(stat_pkts), .stat_drops(stat_drops), .stat_errs(stat_errs)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned   cyc;
    logic          wr;
    logic [DW-1:0] data;
    logic          drop;
    logic          err;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          pending_err = 1'b0;
  bit          prev_wr = 1'b0;
  int unsigned m_pkts = 0, m_drops = 0, m_errs = 0;
  int          pm[$];
  logic        rst_next = 1'b1;
  int          fc_next = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: every cycle the DUT presents an output event, match it to the scoreboard.
  always @(negedge Clk) begin
    ev_t e;
    if (fifo_wr === 1'b1 || pkt_drop === 1'b1 || InBus_Error === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL extra_output cyc=%0d actual wr=%b drop=%b err=%b, required no output",
                 cyc, fifo_wr, pkt_drop, InBus_Error);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.wr !== fifo_wr || e.drop !== pkt_drop || e.err !== InBus_Error ||
            (e.wr && e.data !== fifo_data_in)) begin
          n_fail++;
          $display("FAIL output_event actual cyc=%0d wr=%b drop=%b err=%b data=%h required cyc=%0d wr=%b drop=%b err=%b data=%h",
                   cyc, fifo_wr, pkt_drop, InBus_Error, fifo_data_in,
                   e.cyc, e.wr, e.drop, e.err, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Keep the first m bytes counted from the MSB end, zero the rest.
  function automatic logic [DW-1:0] keep_bytes(input logic [DW-1:0] d, input int m);
    logic [DW-1:0] r;
    r = '0;
    for (int b = 0; b < B; b++) begin
      if (b < m) r[DW-1-8*b -: 8] = d[DW-1-8*b -: 8];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_dat();
    return {$urandom, $urandom};
  endfunction

  task automatic drive(input logic val, input logic sop, input logic eop, input int mod,
                       input logic [DW-1:0] dat);
    @(negedge Clk);
    Rst        = rst_next;
    fifo_count = CW'(fc_next);
    InBus_Val  = val;
    InBus_Sop  = sop;
    InBus_Eop  = eop;
    InBus_Mod  = MW'(mod);
    InBus_Dat  = dat;
  endtask

  // Drive one bus cycle and record the output event it must cause one cycle later.
  task automatic word(input logic val, input logic sop, input logic eop, input int mod,
                      input logic [DW-1:0] dat, input bit wr, input bit drop, input bit err);
    ev_t e;
    drive(val, sop, eop, mod, dat);
    if (wr || drop || err) begin
      e.cyc  = cyc + 1;
      e.wr   = wr;
      e.data = wr ? keep_bytes(dat, mod) : '0;
      e.drop = drop;
      e.err  = err;
      exp_q.push_back(e);
    end
    prev_wr = wr;
    if (drop) m_drops++;
    if (err) m_errs++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) word(1'b0, 1'b0, 1'b0, B, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Well-formed word sizes for a packet of len bytes spread over n words.
  task automatic layout(input int len, input int n);
    pm.delete();
    for (int i = 0; i < n; i++) pm.push_back((i == n - 1) ? len - B * (n - 1) : B);
  endtask

  // Send a packet whose per-word Mod values are in pm; the model decides admission and
  // which words are written and which cycles carry an error, from the packet as a whole.
  task automatic send(input int len, input int fc, input bit trunc);
    int            need, free, n, total;
    bit            acc, eop, wr, err, drop;
    logic [DW-1:0] d;
    n     = pm.size();
    need  = (len + B - 1) / B;
    free  = DEPTH - fc - int'(prev_wr);
    acc   = (len >= 2) && (need <= free);
    total = (n == 1) ? pm[0] : pm[0] + B * (n - 2) + pm[n-1];
    fc_next = fc;
    for (int i = 0; i < n; i++) begin
      eop = (i == n - 1) && !trunc;
      d   = rnd_dat();
      if (i == 0) d[DW-1 -: 16] = 16'(len);
      wr = 1'b0; err = 1'b0; drop = 1'b0;
      if (i == 0) begin
        err  = pending_err || (len < 2);
        drop = (len >= 2) && !acc;
        wr   = acc;
        if (acc && eop && pm[0] != len) err = 1'b1;
        pending_err = 1'b0;
      end else if (acc) begin
        wr  = (i < need);
        err = (i >= need) || (!eop && pm[i] != B) || (eop && total != len);
      end
      word(1'b1, i == 0, eop, pm[i], d, wr, drop, err);
    end
    if (acc && trunc) pending_err = 1'b1;
    if (acc && !trunc) m_pkts++;
    pm.delete();
  endtask

  initial begin
    int kind, len, need, fc, n, j;
    bit after_trunc;
    logic [DW-1:0] hdr;

    // Reset held while a valid header is presented: nothing may come out.
    rst_next = 1'b1;
    hdr = rnd_dat();
    hdr[DW-1 -: 16] = 16'd20;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, B, hdr);
    chk("reset_fifo_wr", DW'(fifo_wr), '0);
    chk("reset_fifo_data_in", fifo_data_in, '0);
    chk("reset_pkt_drop", DW'(pkt_drop), '0);
    chk("reset_InBus_Error", DW'(InBus_Error), '0);
    rst_next = 1'b0;
    idle(2);

    // 20-byte packet in three words, last one half-filled.
    pm = '{8, 8, 4};
    send(20, 0, 1'b0);
    idle(2);
    // Single word claiming 16 bytes but carrying 8.
    pm = '{8};
    send(16, 0, 1'b0);
    idle(2);
    // No room for 3 words with 510 held; then accepted with an empty FIFO.
    pm = '{8, 8, 8};
    send(24, 510, 1'b0);
    idle(1);
    pm = '{8, 8, 4};
    send(20, 0, 1'b0);
    idle(2);
    // Header plus two words, then a new header without Eop.
    pm = '{8, 8, 8};
    send(32, 0, 1'b1);
    pm = '{8, 8, 4};
    send(20, 0, 1'b0);
    idle(2);
    // Word without a header while idle.
    word(1'b1, 1'b0, 1'b0, B, rnd_dat(), 1'b0, 1'b0, 1'b1);
    idle(1);
    // Reset in the middle of a packet.
    pm = '{8};
    send(32, 0, 1'b1);
    rst_next = 1'b1;
    drive(1'b1, 1'b0, 1'b0, B, rnd_dat());
    rst_next = 1'b0;
    pending_err = 1'b0;
    prev_wr = 1'b0;
    m_pkts = 0; m_drops = 0; m_errs = 0;
    // A trailing Eop after reset must be treated as a stray word.
    word(1'b1, 1'b0, 1'b1, B, rnd_dat(), 1'b0, 1'b0, 1'b1);
    chk("fifo_wr_after_mid_reset", DW'(fifo_wr), '0);
    idle(2);

    // Randomized traffic.
    after_trunc = 1'b0;
    for (int p = 0; p < 300; p++) begin
      kind = after_trunc ? 0 : int'($urandom_range(0, 6));
      len  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(65, 200))
                                         : int'($urandom_range(2, 64));
      if (kind == 4) len = $urandom_range(17, 64);
      if (kind == 2) len = $urandom_range(0, 1);
      need = (len + B - 1) / B;
      case (kind)
        1: begin
          n = $urandom_range(1, need);
          layout(B * n, n);
          pm[n-1] = $urandom_range(1, B);
        end
        2: begin
          n = $urandom_range(1, 3);
          layout(B * n, n);
        end
        3: begin
          n = need + int'($urandom_range(1, 2));
          layout(B * n, n);
        end
        4: begin
          layout(len, need);
          j = $urandom_range(1, need - 2);
          pm[j] = $urandom_range(1, B - 1);
        end
        5: begin
          n = $urandom_range(1, need);
          layout(B * n, n);
        end
        default: layout(len, need);
      endcase
      if (kind == 2) fc = $urandom_range(0, DEPTH);
      else if ($urandom_range(0, 3) == 0)
        fc = DEPTH - need - int'(prev_wr) + int'($urandom_range(0, 1));
      else if ($urandom_range(0, 7) == 0) fc = $urandom_range(0, DEPTH);
      else fc = $urandom_range(0, DEPTH - need - 1);
      after_trunc = 1'b0;
      if (kind == 6) begin
        pm.delete();
        word(1'b1, 1'b0, 1'($urandom_range(0, 1)), B, rnd_dat(), 1'b0, 1'b0, 1'b1);
        idle($urandom_range(0, 2));
      end else if (kind == 5) begin
        send(len, fc, 1'b1);
        after_trunc = 1'b1;
      end else begin
        send(len, fc, 1'b0);
        idle($urandom_range(0, 2));
      end
    end

    idle(5);
    chk("scoreboard_drained", DW'(exp_q.size()), '0);
`ifdef PKT_STATS_EN
    chk("stat_pkts", DW'(stat_pkts), DW'(m_pkts));
    chk("stat_drops", DW'(stat_drops), DW'(m_drops));
    chk("stat_errs", DW'(stat_errs), DW'(m_errs));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
